// File: rtl/jtframe_romslot_pkg.sv
// Shared types and address helpers for the N-slot ROM arbiter.
// No logic of its own; constants and pure functions only.
// Word addresses wrap modulo 2^SDRAM_AW by plain truncation.
package jtframe_romslot_pkg;

    localparam int SDRAM_AW = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } st_t;

    // Slot address (in DW units) to 16-bit SDRAM word address
    function automatic logic [SDRAM_AW-1:0] word_addr(
        input logic [SDRAM_AW-1:0] offset,
        input logic [31:0]         addr,
        input int                  dw
    );
        logic [SDRAM_AW-1:0] a;
        case (dw)
            32:      a = SDRAM_AW'(addr << 1);
            16:      a = SDRAM_AW'(addr);
            default: a = SDRAM_AW'(addr >> 1);
        endcase
        return offset + a;
    endfunction

    function automatic int words_per(input int dw);
        return (dw == 32) ? 2 : 1;
    endfunction

endpackage

// File: rtl/jtframe_romslot_tag.sv
// One-entry tagged data register per slot: hit compare, fill and byte select.
// Hit is combinational (zero latency); fill/clear land on the next edge.
// JTFRAME_ROM_NSLOTS_CACHE_EN keeps the tag alive while cs is low.
module jtframe_romslot_tag #(
    parameter int AW = 18,
    parameter int DW = 32,
    parameter int FW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          clr,
    input  logic          fill,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] fill_addr,
    input  logic [FW-1:0] fill_word,
    output logic          ok,
    output logic [DW-1:0] dout
);

    logic [AW-1:0] tag_addr;
    logic          tag_valid;
    logic [DW-1:0] fill_dat;
    logic          drop;

    generate
        if (DW == 8) begin : g_byte
            // Byte slots share a 16-bit word; the low address bit picks the lane
            assign fill_dat = fill_addr[0] ? fill_word[15:8] : fill_word[7:0];
        end else begin : g_word
            assign fill_dat = fill_word[DW-1:0];
        end
    endgenerate

`ifdef JTFRAME_ROM_NSLOTS_CACHE_EN
    assign drop = clr;
`else
    assign drop = clr | ~cs;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_addr  <= '0;
            tag_valid <= 1'b0;
            dout      <= '0;
        end else begin
            if (fill) begin
                tag_addr <= fill_addr;
                dout     <= fill_dat;
            end
            if (drop)
                tag_valid <= 1'b0;
            else if (fill)
                tag_valid <= 1'b1;
        end
    end

    assign ok = cs & tag_valid & (addr == tag_addr);

endmodule

// File: rtl/jtframe_rom_nslots.sv
// Round-robin N-slot read arbiter for one SDRAM bank with per-slot tag registers.
// Hits answer in 0 cycles; a miss raises sdram_req 1 cycle after cs, ok the cycle after data_rdy.
// Slots wait on level cs until served; JTFRAME_ROM_NSLOTS_CACHE_EN keeps tags across cs drops.
module jtframe_rom_nslots
    import jtframe_romslot_pkg::*;
#(
    parameter int                   NSLOTS  = 4,
    parameter int                   AW      = 18,
    parameter int                   DW      = 32,
    parameter logic [NSLOTS*22-1:0] OFFSETS = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSLOTS-1:0]    slot_cs,
    input  logic [NSLOTS*AW-1:0] slot_addr,
    input  logic [NSLOTS-1:0]    slot_clr,
    output logic [NSLOTS-1:0]    slot_ok,
    output logic [NSLOTS*DW-1:0] slot_dout,
    output logic [21:0]          sdram_addr,
    output logic                 sdram_req,
    input  logic                 sdram_ack,
    input  logic                 data_dst,
    input  logic                 data_rdy,
    input  logic [15:0]          data_read
);

    localparam int PW = $clog2(NSLOTS);
    localparam int FW = 16 * words_per(DW);

    st_t               st, st_nxt;
    logic [PW-1:0]     ptr, sel, grant;
    logic              found;
    logic [NSLOTS-1:0] miss;
    logic [AW-1:0]     req_addr;
    logic [FW-1:0]     fill_word;
    logic              fill;
    logic [AW-1:0]     addr_a [NSLOTS];
    logic [21:0]       off_a  [NSLOTS];
    int                idx;

    assign miss = slot_cs & ~slot_ok;

    // Walk backwards so the first miss after ptr is the one left standing
    always_comb begin
        found = 1'b0;
        grant = ptr;
        idx   = 0;
        for (int k = NSLOTS; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NSLOTS;
            if (miss[idx]) begin
                found = 1'b1;
                grant = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (found)     st_nxt = REQ;
            REQ:     if (sdram_ack) st_nxt = DATA;
            DATA:    if (data_rdy)  st_nxt = IDLE;
            default:                st_nxt = IDLE;
        endcase
    end

    always_comb begin
        sdram_req = (st == REQ);
        fill      = (st == DATA) && data_rdy && data_dst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= PW'(NSLOTS - 1);
            sel        <= '0;
            req_addr   <= '0;
            sdram_addr <= '0;
        end else begin
            if (st == IDLE && found) begin
                sel        <= grant;
                req_addr   <= addr_a[grant];
                sdram_addr <= word_addr(off_a[grant], 32'(addr_a[grant]), DW);
            end
            if (fill) ptr <= sel;
        end
    end

    generate
        if (FW == 32) begin : g_asm
            logic [15:0] lo_word;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                          lo_word <= '0;
                else if (st == DATA && data_dst)  lo_word <= data_read;
            end
            assign fill_word = {data_read, lo_word};
        end else begin : g_single
            assign fill_word = data_read;
        end

        for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
            assign addr_a[i] = slot_addr[AW*i +: AW];
            assign off_a[i]  = OFFSETS[22*i +: 22];
            jtframe_romslot_tag #(.AW(AW), .DW(DW), .FW(FW)) u_tag (
                .clk       (clk),
                .rst       (rst),
                .cs        (slot_cs[i]),
                .clr       (slot_clr[i]),
                .fill      (fill && (sel == PW'(i))),
                .addr      (addr_a[i]),
                .fill_addr (req_addr),
                .fill_word (fill_word),
                .ok        (slot_ok[i]),
                .dout      (slot_dout[DW*i +: DW])
            );
        end
    endgenerate

endmodule

// File: doc/jtframe_rom_nslots.md
Name: jtframe_rom_nslots

Overview:
- Generic N-slot read-only arbiter for one SDRAM bank.
- Successor to the fixed 2/3-slot ROM arbiters: slot count, width and per-slot offsets are parameters.
- Arbitration is round-robin instead of fixed priority.
- Each slot keeps a one-entry tagged data register, so a repeated address is answered without an SDRAM access.
- Sits between game-side ROM consumers (tiles, objects, sound, MCU) and one bank port of the SDRAM controller.

Parameters:
- NSLOTS, 4, number of slots, 2..8.
- AW, 18, slot address width in DW-sized units.
- DW, 32, slot data width; legal values 8, 16, 32; common to all slots.
- OFFSETS, 0, packed NSLOTS*22 bits; word offset of slot i in bits [22*i+21:22*i].

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- slot_cs  in  NSLOTS  per-slot read request, level.
- slot_addr  in  NSLOTS*AW  packed slot addresses; slot i in [AW*i+AW-1:AW*i].
- slot_clr  in  NSLOTS  invalidate slot's tagged register.
- slot_ok  out  NSLOTS  data valid for current address.
- slot_dout  out  NSLOTS*DW  packed slot data.
- sdram_addr  out  22  16-bit word address to controller.
- sdram_req  out  1  read request.
- sdram_ack  in  1  request accepted (one cycle).
- data_dst  in  1  one 16-bit word present on data_read (one cycle per word).
- data_rdy  in  1  last word of transfer present (coincides with last data_dst).
- data_read  in  16  SDRAM read data.

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, all tags invalid, FSM=IDLE, round-robin pointer=NSLOTS-1.
- Per-slot tag: tag_addr[i], tag_data[i], tag_valid[i].
- slot_ok[i] = slot_cs[i] & tag_valid[i] & (slot_addr[i]==tag_addr[i]); combinational, so a hit responds with zero latency.
- slot_dout[i] = tag_data[i] at all times.
- Miss: slot_cs[i] & !slot_ok[i].
- FSM states:
  - IDLE: scan misses starting at pointer+1, wrapping modulo NSLOTS. On the first miss found, latch sel=i and the address, drive sdram_addr, set sdram_req=1, go to REQ.
  - REQ: hold sdram_req and sdram_addr until sdram_ack. On ack, drop sdram_req and go to DATA.
  - DATA: on each data_dst, shift the 16-bit word into the assembly register (low half first for DW=32). On data_rdy, write tag_data/tag_addr/tag_valid for sel, set pointer=sel, go to IDLE.
- Latency: the grant registers in IDLE, so sdram_req rises 1 cycle after cs.
- slot_ok rises the cycle after data_rdy, provided the address is unchanged.
- Address mapping, modulo 2^22 (overflow wraps silently):
  - DW=32: OFFSET + {addr,1'b0}, two words.
  - DW=16: OFFSET + addr, one word.
  - DW=8: OFFSET + addr[AW-1:1], one word. On fill, addr[0]=0 stores data_read[7:0] and addr[0]=1 stores data_read[15:8]. The tag holds the full byte address.
- Address changes while the slot's own fetch is in flight: the fetch completes and fills the tag with the latched (old) address. ok stays low; the new address is requested on a later IDLE pass.
- slot_clr[i]: clears tag_valid[i] next edge. If it coincides with the fill of slot i, clr wins.
- A fill of slot i never alters other slots' tags.
- Without the optional feature, tag_valid[i] also clears whenever slot_cs[i]=0.
- data_dst/data_rdy outside DATA are ignored.
- Asynchronous rst mid-transfer: return to reset values immediately. The controller is reset in the same domain.
- Fairness: with all NSLOTS missing, each slot is served exactly once per NSLOTS transfers.

Optional Feature:
- Macro: JTFRAME_ROM_NSLOTS_CACHE_EN.
- Defined: tags persist across slot_cs deassertion and are cleared only by rst or slot_clr. Re-asserting cs on the last fetched address gives immediate ok with no SDRAM access.
- Undefined: the tag is invalidated whenever cs is low, so every new cs assertion refetches.

Decomposition:
- Package jtframe_romslot_pkg:
  - FSM state enum (IDLE, REQ, DATA).
  - SDRAM_AW=22 constant.
  - Function computing word address from (offset, addr, DW).
  - Function returning words-per-access (2 for DW=32, else 1).
- One natural sub-module, jtframe_romslot_tag: per-slot tag register, hit compare and byte select. Instantiated NSLOTS times via generate.
- Arbiter and FSM stay in the top.

Test Plan:
- NSLOTS=4, DW=32, OFFSETS slot2=22'h10_0000: slot2 cs, addr=18'h00010 → sdram_req next cycle with sdram_addr=22'h10_0020. Words 16'h1234 then 16'h5678 (rdy on second) → slot_dout[2]=32'h5678_1234, ok the cycle after rdy.
- All four slots miss simultaneously, pointer=3 → grants in order 0,1,2,3. Then slot0 misses again while slot1 also misses → slot1 is served first only if pointer=0.
- DW=8, addr=16'h0003, data_read=16'hAB12 → dout=8'hAB. Next access to addr=16'h0002 misses and refetches, because the tag is the full address.
- Slot1 address changed from 5 to 6 during DATA → fill tagged 5, ok stays low, second request issued with the address of 6, ok after its rdy.
- Cache enabled: fetch addr 7, drop cs 10 cycles, raise cs with addr 7 → ok same cycle with no sdram_req. Same sequence with slot_clr pulsed in between → refetch. Cache disabled → refetch in both cases.
- rst asserted while in REQ → sdram_req, slot_ok and tags zero immediately. After release, a pending cs re-requests within 1 cycle.
